pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Supervises the clock-generation PLL from the reference-clock side: drives the PLL `rst` input, watches the PLL `locked` output, and produces a clean synchronous reset and ready flag for the downstream 140 MHz and 10 MHz logic. It sits beside the PLL wrapper and is clocked by the same 50 MHz `refclk`. It implements a timed PLL reset pulse, lock timeout with bounded retries, a lock-stability qualification window, lock-loss deglitching and a lock-loss event counter.

## Interface

- `RST_PULSE_CYCLES`, 10: PLL reset pulse width in `refclk` cycles (≥2).
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum cycles in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN.
- `DEGLITCH_CYCLES`, 4: consecutive synchronized-unlocked cycles in RUN that count as lock loss (≥1).
- `MAX_RETRIES`, 3: lock timeouts tolerated before FAIL (≥1).
- `COUNT_W`, 8: width of `lost_count`.

Ports:

- `refclk`  in  1  sole clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock indicator, asynchronous to `refclk`.
- `retry`  in  1  single-cycle pulse; leaves FAIL. Ignored in every other state.
- `pll_rst`  out  1  reset to the PLL, active-high.
- `sys_rst`  out  1  downstream reset, active-high.
- `ready`  out  1  clocks are qualified.
- `fail`  out  1  retries exhausted.
- `lost_count`  out  COUNT_W  saturating count of lock-loss events in RUN.

## Operation

- `locked` passes through a 2-flop synchronizer. Its output, `locked_s`, is the only lock value the FSM uses.
- All outputs are driven directly from flops.
- Each state sets the outputs as follows:
  - PLL_RST: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0.
  - WAIT_LOCK and STABILIZE: `pll_rst`=0, `sys_rst`=1, `ready`=0, `fail`=0.
  - RUN: `pll_rst`=0, `sys_rst`=0, `ready`=1, `fail`=0.
  - FAIL: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=1.
- Reset values:
  - State PLL_RST; all timers, the retry count and `lost_count` are 0.
  - The synchronizer flops are 0.
  - Outputs: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `lost_count`=0.
- FSM transitions:
  - PLL_RST → WAIT_LOCK after exactly `RST_PULSE_CYCLES` cycles. The timer is cleared on entry.
  - WAIT_LOCK → STABILIZE when `locked_s`=1.
  - WAIT_LOCK on timeout, i.e. `LOCK_TIMEOUT_CYCLES` cycles elapse without lock: the retry count increments. If the incremented value equals `MAX_RETRIES`, go to FAIL; otherwise go to PLL_RST.
  - STABILIZE → RUN after `STABLE_CYCLES` consecutive cycles with `locked_s`=1. The retry count clears on entering RUN.
  - STABILIZE → WAIT_LOCK if `locked_s`=0 in any cycle. The timeout timer restarts and the retry count is unchanged.
  - RUN → PLL_RST when `DEGLITCH_CYCLES` consecutive cycles have `locked_s`=0. `lost_count` increments on this transition and saturates at 2^COUNT_W−1.
  - RUN, low run shorter than `DEGLITCH_CYCLES`: the deglitch counter resets on any `locked_s`=1 and no action is taken.
  - FAIL → PLL_RST on `retry`=1. The retry count clears; `lost_count` is retained.
- Boundaries and priority:
  - `rst` overrides everything, including a simultaneous `retry` or lock event.
  - `rst` asserted mid-RUN: outputs return to reset values on the next edge.
  - `lost_count` clears only on `rst`.

## Timing

- Synchronizer latency: 2 edges. If edge k is the first edge to sample `locked`=1, `locked_s`=1 after edge k+1.
- Bring-up:
  - `pll_rst` stays high for exactly `RST_PULSE_CYCLES` edges after the last edge sampling `rst`=1.
  - From edge k above, STABILIZE is entered at edge k+2.
  - `ready` rises and `sys_rst` falls together at edge k+2+`STABLE_CYCLES`.
- Lock loss: if edge k is the first edge to sample `locked`=0 in RUN, `ready` falls and `sys_rst`/`pll_rst` rise together at edge k+1+`DEGLITCH_CYCLES`.
- Timeout: the FSM spends exactly `LOCK_TIMEOUT_CYCLES` cycles in WAIT_LOCK before leaving it.
- `retry` in FAIL: `fail` falls at the next edge. `pll_rst` stays 1 and is high for `RST_PULSE_CYCLES` cycles counted from that edge.

## Test plan

All scenarios use R=4, T=20, S=8, D=3, MAX_RETRIES=2, COUNT_W=2.

- Bring-up:
  - Stimulus: release `rst`; raise `locked` 5 cycles after `pll_rst` falls; hold it high.
  - Required: `pll_rst` high 4 cycles after reset release. `ready`=1 and `sys_rst`=0 exactly 10 edges after the first edge sampling `locked`=1. `fail`=0 and `lost_count`=0 throughout.
- Glitch filter:
  - Stimulus: in RUN, drop `locked` for 2 cycles.
  - Required: `ready` stays 1.
  - Stimulus: then drop `locked` for 3 cycles.
  - Required: `ready` falls 4 edges after the first low sample. `pll_rst` pulses 4 cycles. `lost_count`=1.
- Timeout and FAIL:
  - Stimulus: `locked` held 0.
  - Required: two `pll_rst` pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles. Then `fail`=1, `pll_rst`=1, `sys_rst`=1.
  - Stimulus: `retry` pulse.
  - Required: `fail`=0 next edge; a new 4-cycle reset pulse.
- Stability abort:
  - Stimulus: `locked` drops on the 5th STABILIZE cycle, then returns.
  - Required: FSM back to WAIT_LOCK; `ready` never asserts during the aborted window. Retry count unchanged, so a subsequent single timeout does not cause FAIL.
- Counter saturation:
  - Stimulus: 5 qualified lock-loss events.
  - Required: `lost_count` reads 1, 2, 3, 3, 3.
- Reset mid-operation:
  - Stimulus: `rst` in RUN with `lost_count`=2; also `rst` in FAIL with `retry`=1 in the same cycle.
  - Required: every output at its reset value after the edge (`pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `lost_count`=0).

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the PLL reset, qualifies lock and drives the
// downstream reset/ready flags, all from the refclk domain.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES    = 10,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024,
   parameter int DEGLITCH_CYCLES     = 4,
   parameter int MAX_RETRIES         = 3,
   parameter int COUNT_W             = 8
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               locked,
   input  logic               retry,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [COUNT_W-1:0] lost_count
);

   localparam int TMAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int TMAX_B = (STABLE_CYCLES > DEGLITCH_CYCLES) ? STABLE_CYCLES : DEGLITCH_CYCLES;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int RW     = $clog2(MAX_RETRIES + 1);

   localparam logic [TW-1:0]      C_T_ZERO     = TW'(0);
   localparam logic [TW-1:0]      C_T_ONE      = TW'(1);
   localparam logic [TW-1:0]      C_RST_LAST   = TW'(RST_PULSE_CYCLES - 1);
   localparam logic [TW-1:0]      C_TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]      C_STB_LAST   = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0]      C_DG_LAST    = TW'(DEGLITCH_CYCLES - 1);
   localparam logic [RW-1:0]      C_R_ZERO     = RW'(0);
   localparam logic [RW-1:0]      C_R_ONE      = RW'(1);
   localparam logic [RW-1:0]      C_RETRY_LAST = RW'(MAX_RETRIES - 1);
   localparam logic [COUNT_W-1:0] C_LOST_MAX   = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] C_LOST_ONE   = COUNT_W'(1);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [TW-1:0]      r_timer, w_timer_nxt;
   logic [RW-1:0]      r_retry_cnt, w_retry_nxt;
   logic               w_lost_inc;
   logic               r_sync1, r_locked_s;
   logic               w_pll_rst_nxt, w_sys_rst_nxt, w_ready_nxt, w_fail_nxt;
   logic               r_pll_rst, r_sys_rst, r_ready, r_fail;
   logic [COUNT_W-1:0] r_lost_count;

   // Two-flop synchronizer for the asynchronous PLL lock flag.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_sync1    <= locked;
         r_locked_s <= r_sync1;
      end
   end

   // State, shared phase timer and retry-count registers.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state     <= ST_PLL_RST;
         r_timer     <= C_T_ZERO;
         r_retry_cnt <= C_R_ZERO;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_retry_cnt <= w_retry_nxt;
      end
   end

   // Next-state rules; the timer counts pulse, timeout, stability or deglitch cycles by state.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer + C_T_ONE;
      w_retry_nxt = r_retry_cnt;
      w_lost_inc  = 1'b0;
      case (r_state)
         ST_PLL_RST: begin
            if (r_timer == C_RST_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_timer_nxt = C_T_ZERO;
            end else begin
               w_timer_nxt = r_timer + C_T_ONE;
            end
         end
         ST_WAIT_LOCK: begin
            if (r_locked_s) begin
               w_state_nxt = ST_STABILIZE;
               w_timer_nxt = C_T_ZERO;
            end else if (r_timer == C_TO_LAST) begin
               w_timer_nxt = C_T_ZERO;
               w_retry_nxt = r_retry_cnt + C_R_ONE;
               w_state_nxt = (r_retry_cnt == C_RETRY_LAST) ? ST_FAIL : ST_PLL_RST;
            end else begin
               w_timer_nxt = r_timer + C_T_ONE;
            end
         end
         ST_STABILIZE: begin
            if (!r_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_timer_nxt = C_T_ZERO;
            end else if (r_timer == C_STB_LAST) begin
               w_state_nxt = ST_RUN;
               w_timer_nxt = C_T_ZERO;
               w_retry_nxt = C_R_ZERO;
            end else begin
               w_timer_nxt = r_timer + C_T_ONE;
            end
         end
         ST_RUN: begin
            if (r_locked_s) begin
               w_timer_nxt = C_T_ZERO;
            end else if (r_timer == C_DG_LAST) begin
               w_state_nxt = ST_PLL_RST;
               w_timer_nxt = C_T_ZERO;
               w_lost_inc  = 1'b1;
            end else begin
               w_timer_nxt = r_timer + C_T_ONE;
            end
         end
         ST_FAIL: begin
            w_timer_nxt = C_T_ZERO;
            if (retry) begin
               w_state_nxt = ST_PLL_RST;
               w_retry_nxt = C_R_ZERO;
            end else begin
               w_state_nxt = ST_FAIL;
            end
         end
         default: begin
            w_state_nxt = ST_PLL_RST;
            w_timer_nxt = C_T_ZERO;
            w_retry_nxt = C_R_ZERO;
         end
      endcase
   end

   // Output decode from the upcoming state so the flags switch on the same edge as the state.
   always_comb begin
      w_pll_rst_nxt = 1'b1;
      w_sys_rst_nxt = 1'b1;
      w_ready_nxt   = 1'b0;
      w_fail_nxt    = 1'b0;
      case (w_state_nxt)
         ST_WAIT_LOCK, ST_STABILIZE: w_pll_rst_nxt = 1'b0;
         ST_RUN: begin
            w_pll_rst_nxt = 1'b0;
            w_sys_rst_nxt = 1'b0;
            w_ready_nxt   = 1'b1;
         end
         ST_FAIL: w_fail_nxt    = 1'b1;
         default: w_pll_rst_nxt = 1'b1;
      endcase
   end

   // Output flags and saturating lock-loss counter.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_pll_rst    <= 1'b1;
         r_sys_rst    <= 1'b1;
         r_ready      <= 1'b0;
         r_fail       <= 1'b0;
         r_lost_count <= {COUNT_W{1'b0}};
      end else begin
         r_pll_rst <= w_pll_rst_nxt;
         r_sys_rst <= w_sys_rst_nxt;
         r_ready   <= w_ready_nxt;
         r_fail    <= w_fail_nxt;
         if (w_lost_inc && (r_lost_count != C_LOST_MAX)) begin
            r_lost_count <= r_lost_count + C_LOST_ONE;
         end else begin
            r_lost_count <= r_lost_count;
         end
      end
   end

   assign pll_rst    = r_pll_rst;
   assign sys_rst    = r_sys_rst;
   assign ready      = r_ready;
   assign fail       = r_fail;
   assign lost_count = r_lost_count;

endmodule
